// File: rtl/mlp_pkg.sv
// Shared constants and state encoding for the MLP output post-processing blocks.
package mlp_pkg;

    localparam int NUM_CLASS        = 10;
    localparam int IN_IMG_NUM       = 10;
    localparam int Y_BUF_DATA_WIDTH = 32;
    localparam int Y_BUF_DEPTH      = NUM_CLASS * IN_IMG_NUM * 4;
    localparam int CLS_W            = $clog2(NUM_CLASS);
    localparam int IMG_W            = $clog2(IN_IMG_NUM);
    localparam int ADDR_W           = $clog2(Y_BUF_DEPTH);
    localparam int ADDR_STEP        = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed strict-greater compare with index select. The incumbent is kept on a
// tie, so the lower class index wins when candidates arrive in class order.
module argmax_cmp
    import mlp_pkg::*;
(
    input  logic [Y_BUF_DATA_WIDTH-1:0] cur_val,
    input  logic [CLS_W-1:0]            cur_idx,
    input  logic [Y_BUF_DATA_WIDTH-1:0] new_val,
    input  logic [CLS_W-1:0]            new_idx,
    output logic                        take_new,
    output logic [Y_BUF_DATA_WIDTH-1:0] best_val,
    output logic [CLS_W-1:0]            best_idx
);

    // Pick the new candidate only when it is strictly larger as a signed value.
    always_comb begin
        take_new = ($signed(new_val) > $signed(cur_val));
        best_val = take_new ? new_val : cur_val;
        best_idx = take_new ? new_idx : cur_idx;
    end

endmodule

// File: rtl/mlp_argmax.sv
// Snoops the logit writes on the y_buf port, computes one arg-max class per
// image and collects the predictions into a packed result vector.
//
// Output handshake: pred_valid_o is a single-cycle strobe with no ready; the
// consumer must take pred_img_o/pred_class_o in the cycle it is high. There is
// no backpressure towards the core, every write is absorbed in its own cycle.
module mlp_argmax
    import mlp_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic                          y_buf_en,
    input  logic                          y_buf_wr_en,
    input  logic [ADDR_W-1:0]             y_buf_addr,
    input  logic [Y_BUF_DATA_WIDTH-1:0]   y_buf_data,
    output logic                          pred_valid_o,
    output logic [IMG_W-1:0]              pred_img_o,
    output logic [CLS_W-1:0]              pred_class_o,
    output logic [CLS_W*IN_IMG_NUM-1:0]   pred_vec_o,
    output logic                          all_done_o,
    output logic                          err_o,
    output state_t                        state_o
);

    state_t                        state;
    state_t                        state_nxt;

    logic [CLS_W-1:0]              cls_cnt;
    logic [IMG_W-1:0]              img_cnt;
    logic [ADDR_W-1:0]             exp_addr;
    logic [Y_BUF_DATA_WIDTH-1:0]   max_val;
    logic [CLS_W-1:0]              max_idx;

    logic                          wr_hit;
    logic                          wr_acc;
    logic                          wr_in_done;
    logic                          first_cls;
    logic                          last_cls;
    logic                          last_img;

    logic                          cmp_take;
    logic [Y_BUF_DATA_WIDTH-1:0]   cmp_val;
    logic [CLS_W-1:0]              cmp_idx;

    // Write qualification; a start in the same cycle wins and drops the write.
    always_comb begin
        wr_hit     = y_buf_en && y_buf_wr_en;
        wr_acc     = wr_hit && (state == COLLECT) && !start_i;
        wr_in_done = wr_hit && (state == DONE) && !start_i;
        first_cls  = (cls_cnt == '0);
        last_cls   = (cls_cnt == CLS_W'(NUM_CLASS - 1));
        last_img   = (img_cnt == IMG_W'(IN_IMG_NUM - 1));
    end

    // One comparator serves both the running max and the completion decision:
    // on the last class its result is the image's final arg-max.
    argmax_cmp u_cmp (
        .cur_val  (max_val),
        .cur_idx  (max_idx),
        .new_val  (y_buf_data),
        .new_idx  (cls_cnt),
        .take_new (cmp_take),
        .best_val (cmp_val),
        .best_idx (cmp_idx)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start restarts collection from any state.
    always_comb begin
        state_nxt = state;
        if (start_i) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                COLLECT: if (wr_acc && last_cls && last_img) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Running max, counters, address tracking and result publication.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cls_cnt      <= '0;
            img_cnt      <= '0;
            exp_addr     <= '0;
            max_val      <= '0;
            max_idx      <= '0;
            pred_valid_o <= 1'b0;
            pred_img_o   <= '0;
            pred_class_o <= '0;
            pred_vec_o   <= '0;
            all_done_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            pred_valid_o <= 1'b0;
            if (start_i) begin
                cls_cnt    <= '0;
                img_cnt    <= '0;
                exp_addr   <= '0;
                max_val    <= '0;
                max_idx    <= '0;
                pred_vec_o <= '0;
                all_done_o <= 1'b0;
                err_o      <= 1'b0;
            end else if (wr_acc) begin
                // Address is only checked; indexing follows the write order.
                if (y_buf_addr != exp_addr) begin
                    err_o <= 1'b1;
                end
                exp_addr <= exp_addr + ADDR_W'(ADDR_STEP);

                if (first_cls) begin
                    max_val <= y_buf_data;
                    max_idx <= '0;
                end else begin
                    max_val <= cmp_val;
                    max_idx <= cmp_idx;
                end

                if (last_cls) begin
                    cls_cnt      <= '0;
                    img_cnt      <= last_img ? '0 : img_cnt + IMG_W'(1);
                    pred_valid_o <= 1'b1;
                    pred_img_o   <= img_cnt;
                    pred_class_o <= cmp_idx;
                    for (int i = 0; i < IN_IMG_NUM; i++) begin
                        if (img_cnt == IMG_W'(i)) begin
                            pred_vec_o[i*CLS_W +: CLS_W] <= cmp_idx;
                        end
                    end
                    if (last_img) begin
                        all_done_o <= 1'b1;
                    end
                end else begin
                    cls_cnt <= cls_cnt + CLS_W'(1);
                end
            end else if (wr_in_done) begin
                // Overrun past the last image: flag it, keep the results.
                err_o <= 1'b1;
            end
        end
    end

    // Debug view of the FSM.
    assign state_o = state;

    // cmp_take is folded into cmp_val/cmp_idx; kept as a named net for probing.
    logic unused_take;
    assign unused_take = cmp_take;

endmodule

// File: tb/tb_mlp_argmax.sv
// Self-checking bench for mlp_argmax: table-driven corner images, randomized
// runs against an array-based arg-max model, and hand sequences for errors,
// abort and reset.
module tb_mlp_argmax;
    import mlp_pkg::*;

    logic                          clk_i = 1'b0;
    logic                          rstn_i = 1'b0;
    logic                          start_i = 1'b0;
    logic                          y_buf_en = 1'b0;
    logic                          y_buf_wr_en = 1'b0;
    logic [ADDR_W-1:0]             y_buf_addr = '0;
    logic [Y_BUF_DATA_WIDTH-1:0]   y_buf_data = '0;
    logic                          pred_valid_o;
    logic [IMG_W-1:0]              pred_img_o;
    logic [CLS_W-1:0]              pred_class_o;
    logic [CLS_W*IN_IMG_NUM-1:0]   pred_vec_o;
    logic                          all_done_o;
    logic                          err_o;
    state_t                        state_o;

    mlp_argmax dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .y_buf_en     (y_buf_en),
        .y_buf_wr_en  (y_buf_wr_en),
        .y_buf_addr   (y_buf_addr),
        .y_buf_data   (y_buf_data),
        .pred_valid_o (pred_valid_o),
        .pred_img_o   (pred_img_o),
        .pred_class_o (pred_class_o),
        .pred_vec_o   (pred_vec_o),
        .all_done_o   (all_done_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] lg[NUM_CLASS*IN_IMG_NUM];
    logic [CLS_W*IN_IMG_NUM-1:0] exp_vec = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arg-max: first index holding the largest signed value.
    function automatic logic [3:0] ref_argmax(input int img);
        int best = 0;
        for (int c = 1; c < NUM_CLASS; c++) begin
            if ($signed(lg[img*NUM_CLASS + c]) > $signed(lg[img*NUM_CLASS + best])) best = c;
        end
        return 4'(best);
    endfunction

    // Every pred_valid_o pulse must match the oldest expected prediction.
    always @(negedge clk_i) begin
        logic [7:0] e;
        if (rstn_i && pred_valid_o) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_pred", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("pred_img", 64'(pred_img_o), 64'(e[7:4]));
                chk("pred_class", 64'(pred_class_o), 64'(e[3:0]));
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic do_start();
        start_i = 1'b1;
        y_buf_en = 1'b0;
        y_buf_wr_en = 1'b0;
        exp_vec = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("start_state", 64'(state_o), 64'(COLLECT));
        chk("start_vec", 64'(pred_vec_o), 64'd0);
        chk("start_done", 64'(all_done_o), 64'd0);
        chk("start_err", 64'(err_o), 64'd0);
    endtask

    task automatic idle_cycle();
        y_buf_en = 1'($urandom_range(0, 1));
        y_buf_wr_en = 1'b0;
        y_buf_addr = 9'($urandom_range(0, 399));
        y_buf_data = $urandom;
        @(negedge clk_i);
        chk("idle_no_pulse", 64'(pred_valid_o), 64'd0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] addr, input logic [31:0] d, input logic exp_pulse);
        y_buf_en = 1'b1;
        y_buf_wr_en = 1'b1;
        y_buf_addr = addr;
        y_buf_data = d;
        @(negedge clk_i);
        chk("pulse_timing", 64'(pred_valid_o), 64'(exp_pulse));
    endtask

    task automatic quiet();
        y_buf_en = 1'b0;
        y_buf_wr_en = 1'b0;
        @(negedge clk_i);
    endtask

    // Send the first n writes of lg[] in order; active=0 means no results expected.
    task automatic send_run(input int n, input int gap_max, input int bad_k, input logic active);
        int img;
        int cls;
        logic [ADDR_W-1:0] addr;
        logic last;
        for (int k = 0; k < n; k++) begin
            img = k / NUM_CLASS;
            cls = k % NUM_CLASS;
            if (gap_max > 0) begin
                int g = $urandom_range(0, gap_max);
                for (int j = 0; j < g; j++) idle_cycle();
            end
            addr = (k == bad_k) ? 9'h0C4 : 9'(k * ADDR_STEP);
            last = active && (cls == NUM_CLASS - 1);
            if (last) begin
                exp_q.push_back({4'(img), ref_argmax(img)});
                exp_vec[img*CLS_W +: CLS_W] = ref_argmax(img);
            end
            wr(addr, lg[k], last);
            if (k == bad_k) chk("addr_err_set", 64'(err_o), 64'd1);
        end
        quiet();
    endtask

    task automatic check_done(input string tag, input logic exp_err);
        chk({tag, "_vec"}, 64'(pred_vec_o), 64'(exp_vec));
        chk({tag, "_all_done"}, 64'(all_done_o), 64'd1);
        chk({tag, "_err"}, 64'(err_o), 64'(exp_err));
        chk({tag, "_state"}, 64'(state_o), 64'(DONE));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NUM_CLASS*IN_IMG_NUM; k++) begin
            case ($urandom_range(0, 3))
                0:       lg[k] = $urandom;
                1:       lg[k] = 32'($urandom_range(0, 7)) - 32'd3;
                2:       lg[k] = 32'h8000_0000 + 32'($urandom_range(0, 2));
                default: lg[k] = 32'h7FFF_FFFF - 32'($urandom_range(0, 2));
            endcase
        end
    endtask

    // ---------------- corner-case table ----------------
    typedef struct {
        logic [31:0] base;
        logic [31:0] peak;
        int          peak_cls;
        int          tie_cls;
        int          exp_cls;
    } tvec_t;
    tvec_t tbl[6];

    initial begin
        int p0;
        logic [CLS_W*IN_IMG_NUM-1:0] vec_snap;

        tbl[0] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 6, -1, 6};  // all negative, -7 wins
        tbl[1] = '{32'd100,       32'd500,       2,  8, 2};  // tie: lower index wins
        tbl[2] = '{32'h8000_0000, 32'h8000_0000, 0, -1, 0};  // all most-negative
        tbl[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFF, 9, -1, 9};  // most-positive at last class
        tbl[4] = '{32'd0,         32'd1,         0, -1, 0};  // peak at first class
        tbl[5] = '{32'hFFFF_FFFF, 32'd0,         5, -1, 5};  // zero beats -1

        // ---- reset state ----
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk("rst_valid", 64'(pred_valid_o), 64'd0);
        chk("rst_img", 64'(pred_img_o), 64'd0);
        chk("rst_class", 64'(pred_class_o), 64'd0);
        chk("rst_vec", 64'(pred_vec_o), 64'd0);
        chk("rst_done", 64'(all_done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_state", 64'(state_o), 64'(IDLE));

        // ---- nominal: peak 1000 at (i+3)%10, others -50, back-to-back ----
        for (int i = 0; i < IN_IMG_NUM; i++)
            for (int c = 0; c < NUM_CLASS; c++)
                lg[i*NUM_CLASS + c] = (c == (i + 3) % 10) ? 32'd1000 : 32'hFFFF_FFCE;
        do_start();
        send_run(100, 0, -1, 1'b1);
        check_done("nominal", 1'b0);
        chk("nominal_pulses", 64'(pulse_cnt), 64'd10);
        for (int i = 0; i < IN_IMG_NUM; i++)
            chk($sformatf("nominal_slot%0d", i), 64'(pred_vec_o[i*CLS_W +: CLS_W]), 64'((i + 3) % 10));

        // ---- table: images 0..5 from the table, 6..9 random ----
        fill_random();
        for (int t = 0; t < 6; t++)
            for (int c = 0; c < NUM_CLASS; c++)
                lg[t*NUM_CLASS + c] = (c == tbl[t].peak_cls || c == tbl[t].tie_cls) ? tbl[t].peak : tbl[t].base;
        do_start();
        send_run(100, 0, -1, 1'b1);
        check_done("table", 1'b0);
        for (int t = 0; t < 6; t++)
            chk($sformatf("tbl%0d_class", t), 64'(pred_vec_o[t*CLS_W +: CLS_W]), 64'(tbl[t].exp_cls));

        // ---- address-order error on image 4, class 5 ----
        fill_random();
        do_start();
        send_run(100, 0, 4*NUM_CLASS + 5, 1'b1);
        check_done("addr_err", 1'b1);

        // ---- gaps with en-only cycles, then an overrun write ----
        fill_random();
        do_start();
        send_run(100, 5, -1, 1'b1);
        check_done("gaps", 1'b0);
        vec_snap = pred_vec_o;
        wr(9'd0, 32'h0000_1234, 1'b0);
        quiet();
        chk("overrun_err", 64'(err_o), 64'd1);
        chk("overrun_vec", 64'(pred_vec_o), 64'(exp_vec));
        chk("overrun_done", 64'(all_done_o), 64'd1);
        chk("overrun_state", 64'(state_o), 64'(DONE));

        // ---- abort mid image 6 with a same-cycle write ----
        fill_random();
        do_start();
        send_run(64, 0, -1, 1'b1);
        p0 = pulse_cnt;
        start_i = 1'b1;
        y_buf_en = 1'b1;
        y_buf_wr_en = 1'b1;
        y_buf_addr = 9'(64 * ADDR_STEP);
        y_buf_data = 32'h7FFF_FFFF;
        exp_vec = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        y_buf_en = 1'b0;
        y_buf_wr_en = 1'b0;
        chk("abort_vec", 64'(pred_vec_o), 64'd0);
        chk("abort_done", 64'(all_done_o), 64'd0);
        chk("abort_err", 64'(err_o), 64'd0);
        chk("abort_valid", 64'(pred_valid_o), 64'd0);
        chk("abort_state", 64'(state_o), 64'(COLLECT));
        chk("abort_pulses", 64'(pulse_cnt - p0), 64'd0);
        fill_random();
        send_run(100, 0, -1, 1'b1);
        check_done("after_abort", 1'b0);

        // ---- reset during image 3, then writes without start ----
        fill_random();
        do_start();
        send_run(35, 0, -1, 1'b1);
        rstn_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;
        chk("mrst_valid", 64'(pred_valid_o), 64'd0);
        chk("mrst_img", 64'(pred_img_o), 64'd0);
        chk("mrst_class", 64'(pred_class_o), 64'd0);
        chk("mrst_vec", 64'(pred_vec_o), 64'd0);
        chk("mrst_done", 64'(all_done_o), 64'd0);
        chk("mrst_err", 64'(err_o), 64'd0);
        chk("mrst_state", 64'(state_o), 64'(IDLE));
        p0 = pulse_cnt;
        send_run(20, 0, -1, 1'b0);
        chk("idle_wr_vec", 64'(pred_vec_o), 64'd0);
        chk("idle_wr_done", 64'(all_done_o), 64'd0);
        chk("idle_wr_err", 64'(err_o), 64'd0);
        chk("idle_wr_state", 64'(state_o), 64'(IDLE));
        chk("idle_wr_pulses", 64'(pulse_cnt - p0), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
